cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
Miss-handling and refill controller between the direct-mapped data cache (4 sets, 4-word blocks, 26-bit tag) and word-addressed main memory. On a cache miss it stalls the pipeline and fetches the 4 words of the missing block one at a time over a request/valid memory interface. It then presents them to the cache as d0..d3 with a one-cycle fill strobe, and releases the stall once the cache reports a hit.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 32, byte address width
CNT_WIDTH, 16, width of the miss statistics counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  pipeline is issuing a load/store this cycle
A  input  ADDR_WIDTH  byte address of the access (same address the cache sees)
hit  input  1  cache Hit for address A
mem_rd_en  output  1  one-cycle read request to main memory
mem_addr  output  ADDR_WIDTH  word-aligned address of the requested word
mem_rdata  input  DATA_WIDTH  read data from memory
mem_rvalid  input  1  mem_rdata valid; at most one response per request; latency ≥1 cycle, unbounded
fill_en  output  1  one-cycle strobe: cache writes block this cycle
fill_tag  output  26  A[31:6] of the missing block
fill_set  output  2  A[5:4] of the missing block
d0, d1, d2, d3  output  DATA_WIDTH each  words at block byte offsets 0, 4, 8, 12
stall  output  1  freeze pipeline
miss_count  output  CNT_WIDTH  number of refills started since reset

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE, word_idx=0, latched base=0, d0..d3=0, miss_count=0.
  - mem_rd_en, fill_en and stall are 0.
  - fill_tag and fill_set are 0.
- States: IDLE, REQ, WAIT, FILL.
- IDLE:
  - stall = req_valid & ~hit (combinational, so the miss stalls in the same cycle).
  - If req_valid & ~hit: latch base=A[31:4], word_idx=0, miss_count++ (wraps at 2^CNT_WIDTH), go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_rd_en=1 for exactly this cycle; mem_addr={base, word_idx, 2'b00}.
  - Next state is WAIT. stall=1.
- WAIT:
  - stall=1, mem_rd_en=0.
  - On mem_rvalid: capture mem_rdata into d[word_idx].
    - If word_idx==3, go to FILL.
    - Otherwise word_idx++ and go to REQ.
  - Without mem_rvalid: stay in WAIT indefinitely (no timeout).
- FILL:
  - fill_en=1 for exactly one cycle; stall=1.
  - d0..d3, fill_tag and fill_set are stable from FILL entry until the next miss is latched.
  - Next state is IDLE. In that cycle the cache already holds the block, so hit=1 and stall drops.
- Only one request is outstanding at any time.
- mem_rvalid outside WAIT is ignored, with no state or data change.
- mem_addr holds its last value outside REQ.
- A and req_valid are ignored outside IDLE; the pipeline holds them stable while stall=1.
- Minimum miss penalty, with 1-cycle memory latency (mem_rvalid in the cycle after mem_rd_en):
  - miss detected at T0 (IDLE).
  - REQ/WAIT pairs at T1..T8.
  - FILL at T9.
  - hit and stall low at T10.
- Reset mid-operation (any state): abort immediately to the reset values. Partial words are discarded and fill_en is never issued for an aborted refill.
- A late mem_rvalid arriving after reset is ignored, because the controller is then in IDLE.
- Miss in the IDLE cycle right after FILL (different address with ~hit): a new refill starts that same cycle.

Test Plan:
1. Cold miss, 1-cycle memory: rst for 2 cycles, then req_valid=1, A=0x0000_0040, hit=0; memory returns 0x11,0x22,0x33,0x44 for addresses 0x40/0x44/0x48/0x4C -> mem_addr sequence 0x40,0x44,0x48,0x4C; fill_en at T9 with fill_tag=0x1, fill_set=0, d0..d3=0x11..0x44; stall high T0..T9; miss_count=1.
2. Hit path: req_valid=1, hit=1, A=0x0000_0044 in IDLE -> stall=0, mem_rd_en never asserted, miss_count unchanged.
3. Variable latency: miss at A=0x0000_0130 with rvalid delays of 1, 5, 3, 2 cycles -> exactly 4 mem_rd_en pulses at 0x130,0x134,0x138,0x13C; fill_set=3, fill_tag=0x4; stall continuous until FILL completes; a spurious mem_rvalid during REQ is ignored.
4. Reset mid-refill: assert rst in WAIT after 2 words received -> next cycle state IDLE, stall=0, d0..d3=0, miss_count=0; the following miss re-fetches from word 0.
5. Back-to-back misses: new address A=0x0000_1000 with hit=0 in the IDLE cycle after FILL -> REQ entered the next cycle at 0x1000, miss_count increments to 2.
6. Counter wrap: with CNT_WIDTH=2, perform 5 refills -> miss_count reads 1.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss handler for a 4-set, 4-word-block direct-mapped data cache.
// Fetches the missing block word by word and hands it over with a fill strobe.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  hit,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-7:0] fill_tag,
    output logic [1:0]            fill_set,
    output logic [DATA_WIDTH-1:0] d0,
    output logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] d2,
    output logic [DATA_WIDTH-1:0] d3,
    output logic                  stall,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] FILL = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [1:0]            word_idx;
    logic [ADDR_WIDTH-5:0] base;
    logic                  miss;
    logic                  unused_a;

    assign unused_a  = ^A[3:0];
    assign miss      = req_valid & ~hit;
    assign mem_rd_en = (state == REQ);
    assign fill_en   = (state == FILL);

    always_comb begin
        stall = 1'b1;
        unique case (state)
            IDLE:    stall = miss;
            default: stall = 1'b1;
        endcase
    end

    // mem_addr is registered so it naturally holds outside REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_idx   <= 2'd0;
            base       <= '0;
            mem_addr   <= '0;
            fill_tag   <= '0;
            fill_set   <= 2'd0;
            d0         <= '0;
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            miss_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        base       <= A[ADDR_WIDTH-1:4];
                        word_idx   <= 2'd0;
                        mem_addr   <= {A[ADDR_WIDTH-1:4], 4'b0000};
                        miss_count <= miss_count + CNT_ONE;
                        state      <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    if (mem_rvalid) begin
                        unique case (word_idx)
                            2'd0: d0 <= mem_rdata;
                            2'd1: d1 <= mem_rdata;
                            2'd2: d2 <= mem_rdata;
                            default: d3 <= mem_rdata;
                        endcase
                        if (word_idx == 2'd3) begin
                            fill_tag <= base[ADDR_WIDTH-5:2];
                            fill_set <= base[1:0];
                            state    <= FILL;
                        end else begin
                            word_idx <= word_idx + 2'd1;
                            mem_addr <= {base, word_idx + 2'd1, 2'b00};
                            state    <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a hand-driven memory.
// Inputs change on the falling edge; outputs are sampled there as well.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] A = '0;
    logic        hit = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    logic        mem_rd_en, fill_en, stall;
    logic [31:0] mem_addr, d0, d1, d2, d3;
    logic [25:0] fill_tag;
    logic [1:0]  fill_set;
    logic [15:0] miss_count;

    logic        w_rd_en, w_fill_en, w_stall;
    logic [31:0] w_addr, w_d0, w_d1, w_d2, w_d3;
    logic [25:0] w_tag;
    logic [1:0]  w_set;
    logic [1:0]  w_miss_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .A(A), .hit(hit),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_en(fill_en), .fill_tag(fill_tag), .fill_set(fill_set),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .stall(stall), .miss_count(miss_count)
    );

    cache_refill_ctrl #(.CNT_WIDTH(2)) u_wrap (
        .clk(clk), .rst(rst), .req_valid(req_valid), .A(A), .hit(hit),
        .mem_rd_en(w_rd_en), .mem_addr(w_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_en(w_fill_en), .fill_tag(w_tag), .fill_set(w_set),
        .d0(w_d0), .d1(w_d1), .d2(w_d2), .d3(w_d3),
        .stall(w_stall), .miss_count(w_miss_count)
    );

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        hit = 1'b0;
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic start_miss(input logic [31:0] addr);
        req_valid = 1'b1;
        A = addr;
        hit = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL miss_stall_t0 got=%b exp=1", stall);
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if (miss_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL miss_count got=%0d exp=%0d", miss_count, exp_cnt);
        end
    endtask

    task automatic refill(input logic [31:0] a, input logic [3:0][31:0] d,
                          input logic [3:0][7:0] lat, input bit spur,
                          output int fcyc);
        int cyc;
        bit ok;
        cyc = 1;
        ok = 1'b1;
        fcyc = 0;
        for (int w = 0; w < 4; w++) begin
            int k;
            k = 0;
            while (mem_rd_en !== 1'b1 && k < 4) begin
                @(negedge clk);
                cyc++;
                k++;
            end
            checks++;
            if (mem_rd_en !== 1'b1) begin
                errors++;
                $display("FAIL req_timeout word=%0d got=%b exp=1", w, mem_rd_en);
                ok = 1'b0;
                break;
            end
            checks++;
            if (mem_addr !== a + 32'(4 * w)) begin
                errors++;
                $display("FAIL mem_addr word=%0d got=%h exp=%h",
                         w, mem_addr, a + 32'(4 * w));
            end
            if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            for (int j = 1; j < int'(lat[w]); j++) begin
                checks++;
                if (mem_rd_en !== 1'b0 || stall !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_state rd_en=%b stall=%b exp 0/1",
                             mem_rd_en, stall);
                end
                @(negedge clk);
                cyc++;
            end
            mem_rvalid = 1'b1;
            mem_rdata = d[w];
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
        end
        if (ok) begin
            fcyc = cyc;
            checks++;
            if (fill_en !== 1'b1 || stall !== 1'b1) begin
                errors++;
                $display("FAIL fill_strobe fill_en=%b stall=%b exp 1/1",
                         fill_en, stall);
            end
            checks++;
            if (fill_tag !== a[31:6] || fill_set !== a[5:4]) begin
                errors++;
                $display("FAIL fill_tagset got=%h/%0d exp=%h/%0d",
                         fill_tag, fill_set, a[31:6], a[5:4]);
            end
            checks++;
            if ({d3, d2, d1, d0} !== {d[3], d[2], d[1], d[0]}) begin
                errors++;
                $display("FAIL fill_data got=%h %h %h %h exp=%h %h %h %h",
                         d0, d1, d2, d3, d[0], d[1], d[2], d[3]);
            end
            hit = 1'b1;
            @(negedge clk);
            checks++;
            if (fill_en !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL after_fill fill_en=%b stall=%b exp 0/0",
                         fill_en, stall);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (stall !== 1'b0 || mem_rd_en !== 1'b0 || fill_en !== 1'b0 ||
            fill_tag !== '0 || fill_set !== '0 || mem_addr !== '0 ||
            {d0, d1, d2, d3} !== '0 || miss_count !== '0) begin
            errors++;
            $display("FAIL reset_state stall=%b rd=%b fe=%b tag=%h cnt=%0d exp all 0",
                     stall, mem_rd_en, fill_en, fill_tag, miss_count);
        end
    endtask

    task automatic test_cold_miss();
        int fc;
        start_miss(32'h0000_0040);
        refill(32'h0000_0040, {32'h44, 32'h33, 32'h22, 32'h11},
               {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, fc);
        checks++;
        if (fc !== 9) begin
            errors++;
            $display("FAIL fill_cycle got=T%0d exp=T9", fc);
        end
    endtask

    task automatic test_hit();
        A = 32'h0000_0044;
        hit = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall !== 1'b0 || mem_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL hit_path stall=%b rd_en=%b exp 0/0",
                         stall, mem_rd_en);
            end
            @(negedge clk);
        end
        checks++;
        if (miss_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL hit_count got=%0d exp=%0d", miss_count, exp_cnt);
        end
    endtask

    task automatic test_var_latency();
        int fc;
        start_miss(32'h0000_0130);
        refill(32'h0000_0130, {32'hA4, 32'hA3, 32'hA2, 32'hA1},
               {8'd2, 8'd3, 8'd5, 8'd1}, 1'b1, fc);
    endtask

    task automatic test_reset_mid();
        int fc;
        start_miss(32'h0000_0200);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata = 32'hB0 + 32'(w);
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 32'h208) begin
            errors++;
            $display("FAIL mid_req rd_en=%b addr=%h exp 1/208", mem_rd_en, mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        checks++;
        if (stall !== 1'b0 || {d0, d1, d2, d3} !== '0 ||
            miss_count !== '0 || fill_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset stall=%b d0=%h d1=%h cnt=%0d exp 0",
                     stall, d0, d1, miss_count);
        end
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if (d0 !== '0 || stall !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid d0=%h stall=%b rd_en=%b exp 0", d0, stall, mem_rd_en);
        end
        start_miss(32'h0000_0200);
        refill(32'h0000_0200, {32'hC3, 32'hC2, 32'hC1, 32'hC0},
               {8'd1, 8'd2, 8'd1, 8'd1}, 1'b0, fc);
    endtask

    task automatic test_back_to_back();
        int fc;
        start_miss(32'h0000_0800);
        refill(32'h0000_0800, {32'h4, 32'h3, 32'h2, 32'h1},
               {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, fc);
        start_miss(32'h0000_1000);
        refill(32'h0000_1000, {32'h8, 32'h7, 32'h6, 32'h5},
               {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, fc);
    endtask

    task automatic test_wrap();
        int fc;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            start_miss(32'(i) << 6);
            refill(32'(i) << 6, {32'(i), 32'(i), 32'(i), 32'(i)},
                   {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, fc);
        end
        checks++;
        if (w_miss_count !== 2'd1) begin
            errors++;
            $display("FAIL cnt_wrap got=%0d exp=1", w_miss_count);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_var_latency();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
